mult_seq_64: RTL and testbench



---
 rtl/mult_pkg.sv | 20 ++
 rtl/addsub_64.sv | 24 ++
 rtl/mult_step_64.sv | 63 ++++++
 rtl/mult_seq_64.sv | 108 ++++++++++
 tb/tb_mult_seq_64.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg : shared types and constants for the 64x64 sequential multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_WIDTH = 64;
    localparam int MULT_STEPS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/addsub_64.sv
// ============================================================================
// addsub_64 : 64-bit adder/subtractor, S = A + B or A - B with carry/overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module addsub_64 (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Sub,
    output logic [63:0] S,
    output logic        carry_out,
    output logic        overflow
);

    logic [63:0] w_b_eff;

    assign w_b_eff                = B ^ {64{Sub}};
    assign {carry_out, S}         = {1'b0, A} + {1'b0, w_b_eff} + {64'd0, Sub};
    assign overflow               = (A[63] == w_b_eff[63]) && (S[63] != A[63]);

endmodule

`default_nettype wire

// File: rtl/mult_step_64.sv
// ============================================================================
// mult_step_64 : one Booth / shift-add iteration producing next {ACC,Q,q_m1}
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_step_64
    import mult_pkg::*;
(
    input  logic [MULT_WIDTH-1:0] acc,
    input  logic [MULT_WIDTH-1:0] q,
    input  logic [MULT_WIDTH-1:0] m,
    input  logic                  q_m1,
    input  logic                  sgn,
    output logic [MULT_WIDTH-1:0] acc_next,
    output logic [MULT_WIDTH-1:0] q_next,
    output logic                  q_m1_next
);

    logic                  w_sub;
    logic                  w_use_sum;
    logic                  w_new_msb;
    logic [MULT_WIDTH-1:0] w_sum;
    logic [MULT_WIDTH-1:0] w_r;
    logic                  w_cout;
    logic                  w_ovf;

    addsub_64 u_addsub (
        .A         (acc),
        .B         (m),
        .Sub       (w_sub),
        .S         (w_sum),
        .carry_out (w_cout),
        .overflow  (w_ovf)
    );

    always_comb begin
        w_sub     = 1'b0;
        w_use_sum = 1'b0;
        w_new_msb = 1'b0;
        if (sgn) begin
            case ({q[0], q_m1})
                2'b01:   w_use_sum = 1'b1;
                2'b10: begin
                    w_use_sum = 1'b1;
                    w_sub     = 1'b1;
                end
                default: w_use_sum = 1'b0;
            endcase
            // The true 65-bit sign of the sum survives even when it overflows 64 bits.
            w_new_msb = w_use_sum ? (w_sum[MULT_WIDTH-1] ^ w_ovf) : acc[MULT_WIDTH-1];
        end else begin
            w_use_sum = q[0];
            w_new_msb = q[0] ? w_cout : 1'b0;
        end
    end

    assign w_r                             = w_use_sum ? w_sum : acc;
    assign {acc_next, q_next, q_m1_next}   = {w_new_msb, w_r, q};

endmodule

`default_nettype wire

// File: rtl/mult_seq_64.sv
// ============================================================================
// mult_seq_64 : iterative 64x64->128 multiplier (signed Booth / unsigned)
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_seq_64
    import mult_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    is_signed,
    input  logic [MULT_WIDTH-1:0]   a,
    input  logic [MULT_WIDTH-1:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [2*MULT_WIDTH-1:0] product
);

    localparam logic [6:0] c_LAST_CNT = 7'(MULT_STEPS - 1);

    mult_state_t             r_state;
    mult_state_t             w_state_next;
    logic [MULT_WIDTH-1:0]   r_m;
    logic [MULT_WIDTH-1:0]   r_acc;
    logic [MULT_WIDTH-1:0]   r_q;
    logic                    r_q_m1;
    logic                    r_sgn;
    logic [6:0]              r_cnt;
    logic [2*MULT_WIDTH-1:0] r_product;
    logic                    w_accept;
    logic                    w_last;
    logic [MULT_WIDTH-1:0]   w_acc_next;
    logic [MULT_WIDTH-1:0]   w_q_next;
    logic                    w_q_m1_next;

    mult_step_64 u_step (
        .acc       (r_acc),
        .q         (r_q),
        .m         (r_m),
        .q_m1      (r_q_m1),
        .sgn       (r_sgn),
        .acc_next  (w_acc_next),
        .q_next    (w_q_next),
        .q_m1_next (w_q_m1_next)
    );

    assign w_last = (r_cnt == c_LAST_CNT);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = start;
                if (start) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_accept     = start;
                w_state_next = start ? RUN : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_sgn     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_m    <= a;
                r_q    <= b;
                r_acc  <= '0;
                r_q_m1 <= 1'b0;
                r_cnt  <= '0;
                r_sgn  <= is_signed;
            end else if (r_state == RUN) begin
                r_acc  <= w_acc_next;
                r_q    <= w_q_next;
                r_q_m1 <= w_q_m1_next;
                r_cnt  <= r_cnt + 7'd1;
                // Product is published only on the final iteration; earlier results stay visible.
                if (w_last) r_product <= {w_acc_next, w_q_next};
            end
        end
    end

    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_64.sv
// ============================================================================
// tb_mult_seq_64 : randomized self-checking bench with a behavioural product model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ps/1ps

module tb_mult_seq_64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         busy;
    logic         done;
    logic [127:0] product;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mult_seq_64 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #10000 clk = ~clk;

    function automatic logic [127:0] ref_mul(input bit s, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] ex;
        logic [127:0] ey;
        ex = s ? {{64{x[63]}}, x} : {64'd0, x};
        ey = s ? {{64{y[63]}}, y} : {64'd0, y};
        return ex * ey;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: a job takes 64 cycles after acceptance, then shows done for one cycle.
    bit           m_run  = 1'b0;
    bit           m_done = 1'b0;
    int           m_cyc  = 0;
    logic [127:0] m_pend = '0;
    logic [127:0] m_prod = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
        end else if (!m_run && start) begin
            m_run  = 1'b1;
            m_done = 1'b0;
            m_cyc  = 0;
            m_pend = ref_mul(is_signed, a, b);
        end else if (m_run) begin
            m_cyc++;
            if (m_cyc == 64) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_prod = m_pend;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", {127'd0, busy}, {127'd0, m_run});
            chk("model_done", {127'd0, done}, {127'd0, m_done});
            chk("model_product", product, m_prod);
        end
    end

    task automatic wait_done(input bit scr, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) begin
                start = 1'b0;
                return;
            end
            if (scr) begin
                start     = 1'($urandom);
                is_signed = 1'($urandom);
                a         = {$urandom, $urandom};
                b         = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
        end
        chk("done_timeout", 128'd0, 128'd1);
        lat = -1;
    endtask

    task automatic launch(input bit s, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        a         = x;
        b         = y;
    endtask

    task automatic run_op(input bit s, input logic [63:0] x, input logic [63:0] y,
                          input bit scr, output int lat, output int bcnt);
        launch(s, x, y);
        wait_done(scr, lat, bcnt);
    endtask

    logic [63:0] corners [5];

    initial begin
        int lat;
        int bcnt;
        logic [63:0] x;
        logic [63:0] y;
        corners[0] = 64'd0;
        corners[1] = 64'd1;
        corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        corners[3] = 64'h8000_0000_0000_0000;
        corners[4] = 64'h7FFF_FFFF_FFFF_FFFF;

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_product", product, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, lat, bcnt);
        chk("s3xm5_product", product, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
        chk("s3xm5_latency", 128'(lat), 128'd65);
        chk("s3xm5_busy_cycles", 128'(bcnt), 128'd64);

        run_op(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, lat, bcnt);
        chk("smin_sq_product", product, 128'h4000_0000_0000_0000_0000_0000_0000_0000);

        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, bcnt);
        chk("umax_sq_product", product, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        run_op(1'b0, 64'd7, 64'd6, 1'b1, lat, bcnt);
        chk("u7x6_product", product, 128'd42);
        chk("u7x6_latency", 128'(lat), 128'd65);
        @(negedge clk);
        chk("u7x6_done_once", {127'd0, done}, 128'd0);
        chk("u7x6_held", product, 128'd42);

        launch(1'b1, 64'd100, 64'd200);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_product", product, 128'd0);
        reset = 1'b0;
        start = 1'b0;
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd9, 1'b0, lat, bcnt);
        chk("sm7x9_product", product, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1);
        chk("sm7x9_latency", 128'(lat), 128'd65);

        run_op(1'b0, 64'd4, 64'd5, 1'b0, lat, bcnt);
        chk("b2b_first_product", product, 128'd20);
        start = 1'b1; is_signed = 1'b0; a = 64'd2; b = 64'd3;
        @(negedge clk);
        chk("b2b_busy_rise", {127'd0, busy}, 128'd1);
        chk("b2b_done_fall", {127'd0, done}, 128'd0);
        chk("b2b_held", product, 128'd20);
        start = 1'b0;
        wait_done(1'b0, lat, bcnt);
        chk("b2b_second_product", product, 128'd6);
        chk("b2b_latency", 128'(lat + 1), 128'd65);

        for (int n = 0; n < 24; n++) begin
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : {$urandom, $urandom};
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : {$urandom, $urandom};
            run_op(1'($urandom), x, y, 1'($urandom), lat, bcnt);
            chk("rand_latency", 128'(lat), 128'd65);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
